// File: rtl/passthrough_responder_pkg.sv
// Shared types for the passthrough responder.
// FSM encoding and latency counter width.
package passthrough_responder_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/passthrough_responder_mem.sv
// Word storage for the passthrough responder.
// Bit-masked write port, combinational read.
module passthrough_responder_mem
  import passthrough_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] wbiten,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Merge masked write data into the addressed word
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = (mem_q[waddr] & ~wbiten)
                   | (wdata & wbiten);
    end
  end

  // Storage array, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/passthrough_responder.sv
// CPU-interface responder with stall and latency shaping.
// One transaction outstanding; storage in a sub-module.
module passthrough_responder
  import passthrough_responder_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int DEPTH            = 16,
  parameter int RD_LATENCY       = 1,
  parameter int WR_LATENCY       = 1,
  parameter int REQ_STALL_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_cpuif_req,
  input  logic                  s_cpuif_req_is_wr,
  input  logic [ADDR_WIDTH-1:0] s_cpuif_addr,
  input  logic [DATA_WIDTH-1:0] s_cpuif_wr_data,
  input  logic [DATA_WIDTH-1:0] s_cpuif_wr_biten,
  output logic                  s_cpuif_req_stall_wr,
  output logic                  s_cpuif_req_stall_rd,
  output logic                  s_cpuif_rd_ack,
  output logic                  s_cpuif_rd_err,
  output logic [DATA_WIDTH-1:0] s_cpuif_rd_data,
  output logic                  s_cpuif_wr_ack,
  output logic                  s_cpuif_wr_err
);

  localparam int OFFW  = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((64'd1 << OFFW) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A =
    ADDR_WIDTH'(DEPTH);
  localparam logic [LAT_W-1:0] STALL_N =
    LAT_W'(REQ_STALL_CYCLES);
  localparam logic [LAT_W-1:0] RD_LAT_M1 =
    LAT_W'(RD_LATENCY - 1);
  localparam logic [LAT_W-1:0] WR_LAT_M1 =
    LAT_W'(WR_LATENCY - 1);

  state_e                  state_q, state_d;
  logic [LAT_W-1:0]        stall_q, stall_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic                    is_wr_q, is_wr_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   rd_word_q, rd_word_d;

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [IDX_W-1:0]        mem_idx;
  logic                    addr_err;
  logic                    accept;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    addr_q_unused;

  assign word_idx = s_cpuif_addr >> OFFW;
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign addr_err = (|(s_cpuif_addr & OFF_MASK))
                  || (word_idx >= DEPTH_A);

  assign accept = (state_q == ST_IDLE)
               && s_cpuif_req
               && (stall_q == STALL_N);

  assign mem_we = accept && s_cpuif_req_is_wr
               && !addr_err;

  // Captured address kept only for debug visibility
  assign addr_q_unused = ^addr_q;

  passthrough_responder_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (mem_we),
    .waddr  (mem_idx),
    .wdata  (s_cpuif_wr_data),
    .wbiten (s_cpuif_wr_biten),
    .raddr  (mem_idx),
    .rdata  (mem_rdata)
  );

  // Stall is combinational from state, stall count and request
  always_comb begin
    s_cpuif_req_stall_wr = (state_q != ST_IDLE)
      || (s_cpuif_req && s_cpuif_req_is_wr
          && (stall_q < STALL_N));
    s_cpuif_req_stall_rd = (state_q != ST_IDLE)
      || (s_cpuif_req && !s_cpuif_req_is_wr
          && (stall_q < STALL_N));
  end

  // Completion outputs are only driven in RESP
  always_comb begin
    s_cpuif_rd_ack  = (state_q == ST_RESP) && !is_wr_q;
    s_cpuif_wr_ack  = (state_q == ST_RESP) && is_wr_q;
    s_cpuif_rd_err  = s_cpuif_rd_ack && err_q;
    s_cpuif_wr_err  = s_cpuif_wr_ack && err_q;
    s_cpuif_rd_data = s_cpuif_rd_ack ? rd_word_q : '0;
  end

  // Next-state: stall counting, accept capture, latency countdown
  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    lat_d     = lat_q;
    is_wr_d   = is_wr_q;
    err_d     = err_q;
    addr_d    = addr_q;
    rd_word_d = rd_word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_BUSY;
          stall_d   = '0;
          is_wr_d   = s_cpuif_req_is_wr;
          err_d     = addr_err;
          addr_d    = s_cpuif_addr;
          lat_d     = s_cpuif_req_is_wr ? WR_LAT_M1
                                        : RD_LAT_M1;
          rd_word_d = (s_cpuif_req_is_wr || addr_err)
                    ? '0 : mem_rdata;
        end else if (s_cpuif_req) begin
          stall_d = stall_q + 1'b1;
        end else begin
          stall_d = '0;
        end
      end
      ST_BUSY: begin
        stall_d = '0;
        if (lat_q == '0) begin
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_RESP: begin
        stall_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        stall_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and captured-transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stall_q   <= '0;
      lat_q     <= '0;
      is_wr_q   <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      rd_word_q <= '0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      lat_q     <= lat_d;
      is_wr_q   <= is_wr_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      rd_word_q <= rd_word_d;
    end
  end

endmodule

// File: tb/tb_passthrough_responder.sv
// Directed bench for passthrough_responder.
// Default instance plus a stall/latency instance.
module tb_passthrough_responder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic        a_req, a_wr;
  logic [31:0] a_addr, a_wdata, a_biten;
  logic        a_stall_wr, a_stall_rd;
  logic        a_rd_ack, a_rd_err, a_wr_ack, a_wr_err;
  logic [31:0] a_rd_data;

  logic        b_req, b_wr;
  logic [31:0] b_addr, b_wdata, b_biten;
  logic        b_stall_wr, b_stall_rd;
  logic        b_rd_ack, b_rd_err, b_wr_ack, b_wr_err;
  logic [31:0] b_rd_data;

  passthrough_responder dut_a (
    .clk                  (clk),
    .rst_n                (rst_n),
    .s_cpuif_req          (a_req),
    .s_cpuif_req_is_wr    (a_wr),
    .s_cpuif_addr         (a_addr),
    .s_cpuif_wr_data      (a_wdata),
    .s_cpuif_wr_biten     (a_biten),
    .s_cpuif_req_stall_wr (a_stall_wr),
    .s_cpuif_req_stall_rd (a_stall_rd),
    .s_cpuif_rd_ack       (a_rd_ack),
    .s_cpuif_rd_err       (a_rd_err),
    .s_cpuif_rd_data      (a_rd_data),
    .s_cpuif_wr_ack       (a_wr_ack),
    .s_cpuif_wr_err       (a_wr_err)
  );

  passthrough_responder #(
    .REQ_STALL_CYCLES (3),
    .RD_LATENCY       (4)
  ) dut_b (
    .clk                  (clk),
    .rst_n                (rst_n),
    .s_cpuif_req          (b_req),
    .s_cpuif_req_is_wr    (b_wr),
    .s_cpuif_addr         (b_addr),
    .s_cpuif_wr_data      (b_wdata),
    .s_cpuif_wr_biten     (b_biten),
    .s_cpuif_req_stall_wr (b_stall_wr),
    .s_cpuif_req_stall_rd (b_stall_rd),
    .s_cpuif_rd_ack       (b_rd_ack),
    .s_cpuif_rd_err       (b_rd_err),
    .s_cpuif_rd_data      (b_rd_data),
    .s_cpuif_wr_ack       (b_wr_ack),
    .s_cpuif_wr_err       (b_wr_err)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] biten;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  // One transaction on the default instance
  task automatic txn_a(input vec_t v, input int n);
    int lat;
    bit got;
    logic stl;
    a_req   = 1'b1;
    a_wr    = v.is_wr;
    a_addr  = v.addr;
    a_wdata = v.wdata;
    a_biten = v.biten;
    @(negedge clk);
    stl = v.is_wr ? a_stall_wr : a_stall_rd;
    chk($sformatf("v%0d stall", n), 64'(stl), 64'd0);
    @(posedge clk);
    #1;
    a_req = 1'b0;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      got = v.is_wr ? a_wr_ack : a_rd_ack;
    end
    chk($sformatf("v%0d latency", n), 64'(lat), 64'd1);
    if (v.is_wr) begin
      chk($sformatf("v%0d wr_err", n),
          64'(a_wr_err), 64'(v.exp_err));
      chk($sformatf("v%0d no rd_ack", n),
          64'(a_rd_ack), 64'd0);
    end else begin
      chk($sformatf("v%0d rd_err", n),
          64'(a_rd_err), 64'(v.exp_err));
      chk($sformatf("v%0d rd_data", n),
          64'(a_rd_data), 64'(v.exp_rdata));
      chk($sformatf("v%0d no wr_ack", n),
          64'(a_wr_ack), 64'd0);
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d ack pulse", n),
        64'({a_rd_ack, a_wr_ack}), 64'd0);
    chk($sformatf("v%0d rd_data idle", n),
        64'(a_rd_data), 64'd0);
  endtask

  // One transaction on the stalled/slow instance
  task automatic txn_b(input logic wr,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input int exp_lat,
                       input logic exp_err,
                       input logic [31:0] exp_data,
                       input string nm);
    int nst;
    int lat;
    bit got;
    b_req   = 1'b1;
    b_wr    = wr;
    b_addr  = addr;
    b_wdata = wdata;
    b_biten = 32'hFFFF_FFFF;
    nst = 0;
    @(negedge clk);
    while ((wr ? b_stall_wr : b_stall_rd) && nst < 20) begin
      nst++;
      @(negedge clk);
    end
    chk({nm, " stall cycles"}, 64'(nst), 64'd3);
    @(posedge clk);
    #1;
    b_req = 1'b0;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      got = wr ? b_wr_ack : b_rd_ack;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    if (wr) begin
      chk({nm, " wr_err"}, 64'(b_wr_err), 64'(exp_err));
    end else begin
      chk({nm, " rd_err"}, 64'(b_rd_err), 64'(exp_err));
      chk({nm, " rd_data"}, 64'(b_rd_data), 64'(exp_data));
    end
    @(posedge clk);
    #1;
    chk({nm, " ack pulse"},
        64'({b_rd_ack, b_wr_ack}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0]  = '{1'b1, 32'h4,  32'hDEADBEEF, 32'hFFFFFFFF,
                 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h4,  32'h0, 32'h0,
                 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h4,  32'h12345678, 32'h0000FFFF,
                 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h4,  32'h0, 32'h0,
                 1'b0, 32'hDEAD5678};
    vecs[4]  = '{1'b0, 32'h40, 32'h0, 32'h0,
                 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h2,  32'h0, 32'h0,
                 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h40, 32'h55555555, 32'hFFFFFFFF,
                 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h4,  32'h0, 32'h0,
                 1'b0, 32'hDEAD5678};
    vecs[8]  = '{1'b0, 32'h0,  32'h0, 32'h0,
                 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h3C, 32'hAAAA5555, 32'hFFFFFFFF,
                 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h3C, 32'h0, 32'h0,
                 1'b0, 32'hAAAA5555};
    vecs[11] = '{1'b0, 32'h80000000, 32'h0, 32'h0,
                 1'b1, 32'h0};
    vecs[12] = '{1'b1, 32'h8,  32'hFFFFFFFF, 32'hFF00FF00,
                 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h8,  32'h0, 32'h0,
                 1'b0, 32'hFF00FF00};

    rst_n = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0;
    a_wdata = '0; a_biten = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0;
    b_wdata = '0; b_biten = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset a acks",
        64'({a_rd_ack, a_wr_ack, a_rd_err, a_wr_err}), 64'd0);
    chk("reset a rd_data", 64'(a_rd_data), 64'd0);
    chk("reset a stalls",
        64'({a_stall_rd, a_stall_wr}), 64'd0);
    chk("reset b acks",
        64'({b_rd_ack, b_wr_ack, b_rd_err, b_wr_err}), 64'd0);
    chk("reset b rd_data", 64'(b_rd_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      txn_a(vecs[i], i);
    end

    // Write then read with request held across the write
    a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h10;
    a_wdata = 32'h0BADF00D; a_biten = 32'hFFFFFFFF;
    @(posedge clk); #1;
    a_wr = 1'b0;
    chk("b2b stall in busy", 64'(a_stall_rd), 64'd1);
    @(posedge clk); #1;
    chk("b2b wr_ack", 64'(a_wr_ack), 64'd1);
    chk("b2b stall in resp", 64'(a_stall_rd), 64'd1);
    chk("b2b rd_ack early", 64'(a_rd_ack), 64'd0);
    @(posedge clk); #1;
    chk("b2b idle no stall", 64'(a_stall_rd), 64'd0);
    chk("b2b idle no ack",
        64'({a_rd_ack, a_wr_ack}), 64'd0);
    @(posedge clk); #1;
    a_req = 1'b0;
    chk("b2b busy no ack", 64'(a_rd_ack), 64'd0);
    @(posedge clk); #1;
    chk("b2b rd_ack", 64'(a_rd_ack), 64'd1);
    chk("b2b rd_data", 64'(a_rd_data), 64'h0BADF00D);
    @(posedge clk); #1;

    txn_b(1'b1, 32'h4,  32'hCAFEF00D, 1, 1'b0, 32'h0, "b wr");
    txn_b(1'b0, 32'h4,  32'h0, 4, 1'b0, 32'hCAFEF00D, "b rd");
    txn_b(1'b0, 32'h44, 32'h0, 4, 1'b1, 32'h0, "b rd oob");

    // Reset while a slow read is in flight
    b_req = 1'b1; b_wr = 1'b0; b_addr = 32'h4;
    repeat (4) @(posedge clk);
    #1;
    b_req = 1'b0;
    @(posedge clk); #1;
    chk("rst pre ack", 64'(b_rd_ack), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst outputs",
        64'({b_rd_ack, b_rd_err, b_wr_ack, b_wr_err,
             b_stall_rd, b_stall_wr}), 64'd0);
    chk("rst rd_data", 64'(b_rd_data), 64'd0);
    #3;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b_rd_ack) seen++;
    end
    chk("rst dropped ack", 64'(seen), 64'd0);
    txn_b(1'b0, 32'h4, 32'h0, 4, 1'b0, 32'h0, "b rd after rst");
    txn_a(vecs[8], 100);
    vecs[1].exp_rdata = 32'h0;
    txn_a(vecs[1], 101);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
